// File: rtl/hilo_div.sv
// ---------------------------------------------------------------------------
// hilo_div : 32-bit radix-2 restoring divider feeding the HI/LO write path
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hilo_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stall_req_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BYZERO  = 2'd1;
    localparam logic [1:0] ST_ON      = 2'd2;
    localparam logic [1:0] ST_END     = 2'd3;
    localparam logic [5:0] ITERATIONS = 6'd32;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [5:0]  cnt;
    logic [5:0]  cnt_nxt;
    logic [64:0] dividend;
    logic [64:0] dividend_nxt;
    logic [31:0] divisor;
    logic [31:0] divisor_nxt;
    logic        neg_quot;
    logic        neg_quot_nxt;
    logic        neg_rem;
    logic        neg_rem_nxt;
    logic [63:0] result_nxt;
    logic        ready_nxt;

    logic        accept;
    logic [31:0] abs_op1;
    logic [31:0] abs_op2;
    logic [32:0] diff;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    assign accept      = start_i & ~annul_i;
    assign abs_op1     = (signed_i & opdata1_i[31]) ? (32'd0 - opdata1_i) : opdata1_i;
    assign abs_op2     = (signed_i & opdata2_i[31]) ? (32'd0 - opdata2_i) : opdata2_i;
    assign diff        = {1'b0, dividend[63:32]} - {1'b0, divisor};
    assign quot_fix    = neg_quot ? (32'd0 - dividend[31:0])  : dividend[31:0];
    assign rem_fix     = neg_rem  ? (32'd0 - dividend[64:33]) : dividend[64:33];
    assign stall_req_o = start_i & ~ready_o & ~annul_i;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; annul always wins over progress
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = (opdata2_i == 32'd0) ? ST_BYZERO : ST_ON;
                end
            end
            ST_BYZERO: begin
                state_nxt = annul_i ? ST_IDLE : ST_END;
            end
            ST_ON: begin
                if (annul_i) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == ITERATIONS) begin
                    state_nxt = ST_END;
                end
            end
            ST_END: begin
                if (annul_i || !start_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        cnt_nxt      = cnt;
        dividend_nxt = dividend;
        divisor_nxt  = divisor;
        neg_quot_nxt = neg_quot;
        neg_rem_nxt  = neg_rem;
        result_nxt   = result_o;
        ready_nxt    = ready_o;
        case (state)
            ST_IDLE: begin
                result_nxt = 64'd0;
                ready_nxt  = 1'b0;
                if (accept) begin
                    cnt_nxt      = 6'd0;
                    dividend_nxt = {32'd0, abs_op1, 1'b0};
                    divisor_nxt  = abs_op2;
                    neg_quot_nxt = signed_i & (opdata1_i[31] ^ opdata2_i[31]);
                    neg_rem_nxt  = signed_i & opdata1_i[31];
                end
            end
            ST_BYZERO: begin
                result_nxt = 64'd0;
                ready_nxt  = 1'b0;
            end
            ST_ON: begin
                if (annul_i) begin
                    result_nxt = 64'd0;
                    ready_nxt  = 1'b0;
                end else if (cnt == ITERATIONS) begin
                    result_nxt = {rem_fix, quot_fix};
                    ready_nxt  = 1'b1;
                end else begin
                    // Restore by simply not committing a negative trial subtraction
                    if (diff[32]) begin
                        dividend_nxt = {dividend[63:0], 1'b0};
                    end else begin
                        dividend_nxt = {diff[31:0], dividend[31:0], 1'b1};
                    end
                    cnt_nxt = cnt + 6'd1;
                end
            end
            ST_END: begin
                if (annul_i || !start_i) begin
                    result_nxt = 64'd0;
                    ready_nxt  = 1'b0;
                end else begin
                    ready_nxt  = 1'b1;
                end
            end
            default: begin
                result_nxt = 64'd0;
                ready_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= 6'd0;
            dividend <= 65'd0;
            divisor  <= 32'd0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            dividend <= dividend_nxt;
            divisor  <= divisor_nxt;
            neg_quot <= neg_quot_nxt;
            neg_rem  <= neg_rem_nxt;
            result_o <= result_nxt;
            ready_o  <= ready_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hilo_div.sv
// ---------------------------------------------------------------------------
// tb_hilo_div : directed and random checks of hilo_div against an arithmetic model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hilo_div;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        signed_i = 1'b0;
    logic [31:0] opdata1_i = 32'd0;
    logic [31:0] opdata2_i = 32'd0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_req_o;

    int n_asserts = 0;
    int n_fails   = 0;

    hilo_div dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .annul_i    (annul_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stall_req_o(stall_req_o)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Reference: 64-bit language division truncates toward zero, remainder takes dividend sign
    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic props_ok(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                      input logic [63:0] res);
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] recon;
        logic [31:0] mr;
        logic [31:0] mb;
        q     = res[31:0];
        r     = res[63:32];
        recon = q * b + r;
        mr    = (sgn && r[31]) ? (32'd0 - r) : r;
        mb    = (sgn && b[31]) ? (32'd0 - b) : b;
        return (recon == a) && (mr < mb);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns one negedge after start_i is dropped
    task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [63:0] res, output int lat, output bit stall_ok);
        signed_i  = sgn;
        opdata1_i = a;
        opdata2_i = b;
        start_i   = 1'b1;
        lat       = 0;
        stall_ok  = 1'b1;
        #1;
        if (stall_req_o !== 1'b1) stall_ok = 1'b0;
        while (ready_o !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
            if (ready_o !== 1'b1 && stall_req_o !== 1'b1) stall_ok = 1'b0;
        end
        if (ready_o === 1'b1 && stall_req_o !== 1'b0) stall_ok = 1'b0;
        res     = result_o;
        start_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic directed(input string tag, input bit sgn, input logic [31:0] a,
                            input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
        logic [63:0] res;
        int          lat;
        bit          stall_ok;
        run_div(sgn, a, b, res, lat, stall_ok);
        check({tag, " result"}, res, exp);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " stall"}, {63'd0, stall_ok}, 64'd1);
        check({tag, " ready after drop"}, {63'd0, ready_o}, 64'd0);
        check({tag, " result after drop"}, result_o, 64'd0);
    endtask

    initial begin
        logic [63:0] res;
        logic [63:0] held;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        int          ready_cycles;
        bit          stall_ok;
        bit          sgn;
        bit          seen_ready;

        repeat (3) @(negedge clk);
        check("reset ready", {63'd0, ready_o}, 64'd0);
        check("reset result", result_o, 64'd0);
        check("reset stall", {63'd0, stall_req_o}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        directed("divu 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34);
        directed("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34);
        directed("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 34);
        directed("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 34);
        directed("divu min/max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, 34);
        directed("divu by zero", 1'b0, 32'h0000_1234, 32'd0, 64'd0, 3);
        directed("div by zero", 1'b1, 32'hFFFF_1234, 32'd0, 64'd0, 3);

        // Annul sampled at E11 while still requesting
        signed_i  = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        repeat (11) @(negedge clk);
        annul_i = 1'b1;
        #1;
        check("annul stall", {63'd0, stall_req_o}, 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        seen_ready = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o !== 1'b0) seen_ready = 1'b1;
        end
        check("annul no ready", {63'd0, seen_ready}, 64'd0);
        directed("divu 9/3 after annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34);

        // Reset sampled at E20
        signed_i  = 1'b1;
        opdata1_i = 32'd5000;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        repeat (20) @(negedge clk);
        rst_n   = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        check("midreset ready", {63'd0, ready_o}, 64'd0);
        check("midreset result", result_o, 64'd0);
        check("midreset stall", {63'd0, stall_req_o}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        directed("divu after reset", 1'b0, 32'd77, 32'd10, {32'd7, 32'd7}, 34);

        // start_i withdrawn mid-divide: result still appears for exactly one cycle
        signed_i  = 1'b0;
        opdata1_i = 32'd123456;
        opdata2_i = 32'd789;
        start_i   = 1'b1;
        repeat (5) @(negedge clk);
        start_i = 1'b0;
        ready_cycles = 0;
        held = 64'd0;
        repeat (45) begin
            @(negedge clk);
            if (ready_o === 1'b1) begin
                ready_cycles++;
                held = result_o;
            end
        end
        check("dropped start ready cycles", 64'(ready_cycles), 64'd1);
        check("dropped start result", held, model(1'b0, 32'd123456, 32'd789));

        for (int i = 0; i < 1000; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = $urandom;
            case ($urandom_range(0, 3))
                0: b = b & 32'h0000_00FF;
                1: b = b & 32'h0000_FFFF;
                2: b = {{16{b[15]}}, b[15:0]};
                default: ;
            endcase
            if (b == 32'd0) b = 32'd1;
            run_div(sgn, a, b, res, lat, stall_ok);
            check("rand result", res, model(sgn, a, b));
            check("rand identity", {63'd0, props_ok(sgn, a, b, res)}, 64'd1);
            check("rand latency", 64'(lat), 64'd34);
            check("rand stall", {63'd0, stall_ok}, 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hilo_div.md
# hilo_div

Multi-cycle 32-bit integer divider, the producing end of the HI/LO write path. The EX stage launches DIV/DIVU through it and forwards its 64-bit result as a HI/LO write. The decode stage's HI/LO forwarding then consumes that write. The block uses a radix-2 restoring algorithm with one quotient bit per clock and raises a stall request to the pipeline controller until the result is ready.

## Interface
- No parameters; data width fixed at 32, iteration count fixed at 32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- start_i  in  1  divide request; held high by EX until ready_o is seen.
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start_i.
- opdata1_i  in  32  dividend; sampled at start.
- opdata2_i  in  32  divisor; sampled at start.
- annul_i  in  1  cancel in-flight divide (flush/exception).
- result_o  out  64  {HI = remainder, LO = quotient}; valid only while ready_o = 1.
- ready_o  out  1  result valid (registered).
- stall_req_o  out  1  combinational: start_i & ~ready_o & ~annul_i.

## Operation
- States: IDLE, BYZERO, ON, END. Registered state: state, cnt[5:0], dividend shift register[64:0], divisor[31:0], latched signed_i/operand signs, result_o, ready_o.
- IDLE:
  - start_i & ~annul_i & opdata2_i==0 → BYZERO.
  - start_i & ~annul_i & opdata2_i!=0 → ON.
  - On that transition: latch magnitudes (negate operand if signed_i and bit31 set), signs, cnt=0, dividend reg = {32'b0, |opdata1_i|, 1'b0}.
  - Otherwise stay IDLE.
- BYZERO: → END with result_o = 64'h0.
- ON, each cycle with cnt<32:
  - diff = dividend[63:32] − divisor (33-bit).
  - diff negative → dividend = {dividend[63:0],1'b0}.
  - diff non-negative → dividend = {diff[31:0], dividend[31:0], 1'b1}.
  - Then cnt += 1.
- ON, cnt==32 → END and register the result:
  - Quotient = dividend[31:0], negated if signed and the operand signs differ.
  - Remainder = dividend[64:33], negated if signed and the dividend is negative.
  - ready_o=1.
- END:
  - Hold result_o, ready_o=1 while start_i=1.
  - start_i=0 → IDLE, ready_o=0, result_o=0.
- annul_i=1 in BYZERO or ON → IDLE next edge, ready_o stays 0, result_o=0, no result emitted. annul_i in END also → IDLE.
- Arithmetic rules:
  - All negation is 32-bit two's complement, wraps.
  - DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
  - Divide-by-zero result is architecturally UNPREDICTABLE; this block defines it as HI=LO=0.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, cnt=0, result_o=0, ready_o=0. Applies mid-operation with no partial result. stall_req_o follows its formula.
- Latency, counting the start-sampling edge as E0:
  - Normal: ON iterates at E1..E32, END and ready_o=1 after E33 (33 clocks).
  - Divide-by-zero: ready_o=1 after E2.
- stall_req_o is high from the cycle start_i rises until the cycle ready_o is high. EX samples result_o when ready_o=1, then drops start_i.
- Back-to-back: a new start_i is only accepted in IDLE, so at least one IDLE cycle separates divides.
- annul_i and cnt==32 in the same cycle: annul wins.
- start_i dropping during ON without annul_i: the divide continues to END, then returns to IDLE the cycle after (start_i=0).

## Test plan
- DIVU 100/7:
  - Stimulus: start at E0.
  - Required: ready_o rises after E33, result_o = {32'd2, 32'd14}; stall_req_o high for cycles E0..E32.
  - Required: drop start_i → IDLE, ready_o=0 next edge.
- DIV −7/2:
  - Required: result_o = {0xFFFFFFFF, 0xFFFFFFFD} (rem −1, quot −3).
  - Repeat 7/−2 → {1, 0xFFFFFFFD}.
- DIV 0x80000000 / 0xFFFFFFFF:
  - Required: {0, 0x80000000}.
  - Same operands as DIVU → {0x80000000, 0}.
- Divisor 0 (dividend 0x1234):
  - Required: ready_o after E2, result_o = 0, state never enters ON.
- Cancel and reset mid-divide:
  - Assert annul_i at E10 → IDLE after E11, ready_o never rises. A following DIVU 9/3 → {0,3} at 33-clock latency.
  - Assert rst_n=0 at E20 of a divide → all outputs 0 next edge.
- Random sweep:
  - Stimulus: 1000 random signed/unsigned pairs with nonzero divisor.
  - Required: compare with a reference model; quotient·divisor + remainder == dividend (mod 2^32), and |rem| < |divisor|.
